// File: rtl/net_stream_host.sv
// Host endpoint for a generated net_*: streams a loaded input vector into the network and
// captures its output stream into a readable result buffer; combinational rd_data, AXI-style stable TX.
module net_stream_host #(
  parameter int T     = 16,
  parameter int N_IN  = 4,
  parameter int N_OUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(N_IN)-1:0]  wr_addr,
  input  logic [T-1:0]             wr_data,
  input  logic                     start,
  output logic                     to_net_valid,
  input  logic                     to_net_ready,
  output logic [T-1:0]             to_net_data,
  input  logic                     from_net_valid,
  output logic                     from_net_ready,
  input  logic [T-1:0]             from_net_data,
  input  logic [$clog2(N_OUT)-1:0] rd_addr,
  output logic [T-1:0]             rd_data,
  output logic                     busy,
  output logic                     done
);

  localparam int AWI = $clog2(N_IN);
  localparam int AWO = $clog2(N_OUT);
  localparam int CWI = $clog2(N_IN + 1);
  localparam int CWO = $clog2(N_OUT + 1);

  localparam logic [CWI-1:0] TX_END  = CWI'(N_IN);
  localparam logic [CWO-1:0] RX_END  = CWO'(N_OUT);
  localparam logic [CWO-1:0] RX_LAST = CWO'(N_OUT - 1);
  localparam logic [AWI:0]   WR_LIM  = (AWI + 1)'(N_IN);
  localparam logic [AWO:0]   RD_LIM  = (AWO + 1)'(N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CWI-1:0] tx_cnt_q, tx_cnt_d;
  logic [CWO-1:0] rx_cnt_q, rx_cnt_d;
  logic [T-1:0]   in_buf_q  [N_IN];
  logic [T-1:0]   out_buf_q [N_OUT];
  logic           tx_fire, rx_fire, wr_ok;

  always_comb begin
    to_net_valid   = (state_q == S_RUN) && (tx_cnt_q < TX_END);
    from_net_ready = (state_q == S_RUN) && (rx_cnt_q < RX_END);
    busy           = (state_q == S_RUN);
    done           = (state_q == S_DONE);
    to_net_data    = to_net_valid ? in_buf_q[tx_cnt_q[AWI-1:0]] : '0;
    tx_fire        = to_net_valid && to_net_ready;
    rx_fire        = from_net_valid && from_net_ready;
    wr_ok          = wr_en && (state_q != S_RUN) && ({1'b0, wr_addr} < WR_LIM);
    state_d        = state_q;
    tx_cnt_d       = tx_cnt_q;
    rx_cnt_d       = rx_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (tx_fire) tx_cnt_d = tx_cnt_q + 1'b1;
        // The final RX beat ends the run even if TX words remain unsent.
        if (rx_fire) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_q == RX_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      for (int i = 0; i < N_OUT; i++) out_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      if (rx_fire) out_buf_q[rx_cnt_q[AWO-1:0]] <= from_net_data;
    end
  end

  // Input vector survives reset so a bench can reload only the words it changes.
  always_ff @(posedge clk) begin
    if (wr_ok) in_buf_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < RD_LIM) rd_data = out_buf_q[rd_addr];
  end

endmodule

// File: tb/tb_net_stream_host.sv
// Directed bench for net_stream_host: a vector table for the basic transfer, then
// hand-written sequences for backpressure, mid-run commands, async reset and an odd N_OUT.
module tb_net_stream_host;

  typedef struct {
    int wr, wa, wd, st, trdy, fv, fd, ra;
    int ev, ed, efr, eb, edn, erd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, wr_en, start, to_ready, fv, start3, fv3;
  logic [1:0]  wr_addr, ra3;
  logic [15:0] wr_data, fd, fd3;
  logic [0:0]  ra;
  logic        tv, frdy, busy, done, tv3, frdy3, busy3, done3;
  logic [15:0] tdat, rdat, tdat3, rdat3;

  int checks = 0;
  int errors = 0;
  vec_t tbl[13];
  int din[4] = '{1, -2, 3, -4};
  int pat[4] = '{1, 0, 0, 1};

  always #5 clk = ~clk;

  net_stream_host #(.T(16), .N_IN(4), .N_OUT(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .to_net_valid(tv), .to_net_ready(to_ready), .to_net_data(tdat),
    .from_net_valid(fv), .from_net_ready(frdy), .from_net_data(fd),
    .rd_addr(ra), .rd_data(rdat), .busy(busy), .done(done));

  net_stream_host #(.T(16), .N_IN(4), .N_OUT(3)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start3), .to_net_valid(tv3), .to_net_ready(to_ready), .to_net_data(tdat3),
    .from_net_valid(fv3), .from_net_ready(frdy3), .from_net_data(fd3),
    .rd_addr(ra3), .rd_data(rdat3), .busy(busy3), .done(done3));

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    //           wr wa  wd st rdy fv   fd  ra ev  ed fr  b dn  rd
    tbl[0]  = '{1, 0,  1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0,   0};
    tbl[1]  = '{1, 1, -2, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0,   0};
    tbl[2]  = '{1, 2,  3, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0,   0};
    tbl[3]  = '{1, 3, -4, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0,   0};
    tbl[4]  = '{0, 0,  0, 1, 1, 0,   0, 0, 0,  0, 0, 0, 0,   0};
    tbl[5]  = '{0, 0,  0, 0, 1, 0,   0, 0, 1,  1, 1, 1, 0,   0};
    tbl[6]  = '{0, 0,  0, 0, 1, 0,   0, 0, 1, -2, 1, 1, 0,   0};
    tbl[7]  = '{0, 0,  0, 0, 1, 1, 100, 0, 1,  3, 1, 1, 0,   0};
    tbl[8]  = '{0, 0,  0, 0, 1, 0,   0, 0, 1, -4, 1, 1, 0, 100};
    tbl[9]  = '{0, 0,  0, 0, 1, 1,  -7, 1, 0,  0, 1, 1, 0,   0};
    tbl[10] = '{0, 0,  0, 0, 1, 1, 999, 1, 0,  0, 0, 0, 1,  -7};
    tbl[11] = '{0, 0,  0, 0, 1, 0,   0, 1, 0,  0, 0, 0, 1,  -7};
    tbl[12] = '{0, 0,  0, 0, 1, 0,   0, 0, 0,  0, 0, 0, 1, 100};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; to_ready = 1'b0;
    fv = 1'b0; fd = '0; ra = '0; start3 = 1'b0; fv3 = 1'b0; fd3 = '0; ra3 = '0;
    #1;
    chk("rst_valid", int'(tv), 0);
    chk("rst_fready", int'(frdy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd0", sx(rdat), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Basic transfer with RX overlapping TX beat 2 and an extra beat after DONE.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_en = (tbl[i].wr != 0); wr_addr = 2'(tbl[i].wa); wr_data = 16'(tbl[i].wd);
      start = (tbl[i].st != 0); to_ready = (tbl[i].trdy != 0);
      fv = (tbl[i].fv != 0); fd = 16'(tbl[i].fd); ra = 1'(tbl[i].ra);
      #1;
      chk($sformatf("v%0d_valid", i), int'(tv), tbl[i].ev);
      if (tbl[i].ev != 0) chk($sformatf("v%0d_data", i), sx(tdat), tbl[i].ed);
      chk($sformatf("v%0d_fready", i), int'(frdy), tbl[i].efr);
      chk($sformatf("v%0d_busy", i), int'(busy), tbl[i].eb);
      chk($sformatf("v%0d_done", i), int'(done), tbl[i].edn);
      chk($sformatf("v%0d_rd", i), sx(rdat), tbl[i].erd);
    end

    // TX backpressure: words must hold while ready is low, exactly four beats in order.
    @(negedge clk); start = 1'b1; to_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    begin : txbp
      int got, pv, pr, pd;
      got = 0; pv = 0; pr = 0; pd = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        to_ready = (pat[cyc % 4] != 0);
        #1;
        if (pv != 0 && pr == 0) begin
          chk("tx_hold_valid", int'(tv), 1);
          chk("tx_hold_data", sx(tdat), pd);
        end
        if (tv && to_ready) begin
          if (got < 4) chk($sformatf("tx_bp_word%0d", got), sx(tdat), din[got]);
          got++;
        end
        pv = int'(tv); pr = int'(to_ready); pd = sx(tdat);
        if (got >= 4 && !tv) break;
        @(negedge clk);
      end
      chk("tx_bp_count", got, 4);
      chk("tx_bp_end_valid", int'(tv), 0);
    end

    // start and wr_en while in RUN are both ignored.
    @(negedge clk); start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd77;
    @(negedge clk); start = 1'b0; wr_en = 1'b0; fv = 1'b1; fd = 16'd5;
    #1;
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_no_restart", int'(tv), 0);
    chk("midrun_done", int'(done), 0);
    chk("midrun_fready", int'(frdy), 1);
    @(negedge clk); fd = 16'd6;
    #1;
    chk("midrun_rx1_fready", int'(frdy), 1);
    @(negedge clk); fv = 1'b0; ra = 1'b0;
    #1;
    chk("midrun_done_set", int'(done), 1);
    chk("midrun_fready_drop", int'(frdy), 0);
    chk("midrun_rd0", sx(rdat), 5);
    ra = 1'b1; #1;
    chk("midrun_rd1", sx(rdat), 6);
    start = 1'b1; to_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    #1;
    chk("restart_done_clr", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_valid", int'(tv), 1);
    chk("restart_word0", sx(tdat), 1);

    // Asynchronous reset during TX beat 2.
    to_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("pre_reset_beat2", sx(tdat), 3);
    #1 reset = 1'b1;
    #1;
    chk("areset_valid", int'(tv), 0);
    chk("areset_fready", int'(frdy), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_done", int'(done), 0);
    ra = 1'b0; #0;
    chk("areset_rd0", sx(rdat), 0);
    ra = 1'b1; #1;
    chk("areset_rd1", sx(rdat), 0);
    @(negedge clk); reset = 1'b0; start = 1'b1; to_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("clean_valid%0d", k), int'(tv), 1);
      chk($sformatf("clean_word%0d", k), sx(tdat), din[k]);
      @(negedge clk);
    end
    #1;
    chk("clean_tx_end", int'(tv), 0);
    fv = 1'b1; fd = 16'd11;
    @(negedge clk); fd = 16'd22;
    @(negedge clk); fv = 1'b0; ra = 1'b0;
    #1;
    chk("clean_done", int'(done), 1);
    chk("clean_rd0", sx(rdat), 11);
    ra = 1'b1; #1;
    chk("clean_rd1", sx(rdat), 22);

    // N_OUT=3: same-edge write+start, then out-of-range read.
    @(negedge clk); wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd55; start3 = 1'b1; to_ready = 1'b1;
    @(negedge clk); wr_en = 1'b0; start3 = 1'b0; fv3 = 1'b1; fd3 = 16'd9;
    #1;
    chk("n3_valid", int'(tv3), 1);
    chk("n3_first_word", sx(tdat3), 55);
    chk("n3_busy", int'(busy3), 1);
    chk("n3_fready", int'(frdy3), 1);
    @(negedge clk); fd3 = 16'd8;
    @(negedge clk); fd3 = 16'd7;
    @(negedge clk); fv3 = 1'b0; ra3 = 2'd2;
    #1;
    chk("n3_done", int'(done3), 1);
    chk("n3_busy_clr", int'(busy3), 0);
    chk("n3_rd2", sx(rdat3), 7);
    ra3 = 2'd3; #1;
    chk("n3_rd_oob", sx(rdat3), 0);
    ra3 = 2'd0; #1;
    chk("n3_rd0", sx(rdat3), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_stream_host.md
Name: net_stream_host

Overview:
- Host-side endpoint for a generated fully-connected network top (`net_*`); it is the opposite end of the network's valid/ready stream ports.
- Holds one input vector loaded through a simple write port. On `start`, it streams that vector into the network's input stream. At the same time it captures the network's output stream into a result buffer, then raises `done`.
- Used as the integration and bench driver for generated networks.

Parameters:
- T, 16, data word width (signed).
- N_IN, 4, number of words in the input vector (network input count).
- N_OUT, 16, number of words in the result vector (network output count).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write enable for the input buffer.
- wr_addr  in  $clog2(N_IN)  input buffer index.
- wr_data  in  T  signed word to write.
- start  in  1  single-cycle pulse that begins a transfer.
- to_net_valid  out  1  drives the network's `input_valid`.
- to_net_ready  in  1  driven by the network's `input_ready`.
- to_net_data  out  T  drives the network's `input_data`.
- from_net_valid  in  1  driven by the network's `output_valid`.
- from_net_ready  out  1  drives the network's `output_ready`.
- from_net_data  in  T  driven by the network's `output_data`.
- rd_addr  in  $clog2(N_OUT)  result buffer index.
- rd_data  out  T  result word (combinational read).
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous, active-high, named `reset`.
- Reset values: FSM=IDLE; tx_cnt=0; rx_cnt=0; to_net_valid=0; from_net_ready=0; busy=0; done=0; result buffer cleared to 0. Input buffer contents are not reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last rx beat--> DONE.
  - DONE --start--> RUN.
  - No other transitions.
- start in RUN is ignored.
- Entering RUN clears tx_cnt, rx_cnt and done.
- Latency: start sampled at edge k -> to_net_valid=1 with to_net_data=in_buf[0] visible after edge k.
- TX side:
  - to_net_valid=1 while state==RUN and tx_cnt<N_IN.
  - to_net_data=in_buf[tx_cnt].
  - A beat transfers on a cycle with valid&ready; tx_cnt increments.
  - After beat N_IN-1, to_net_valid deasserts on the following cycle.
  - Valid never drops and data never changes while ready is low (AXI-style stability).
- RX side:
  - from_net_ready=1 while state==RUN and rx_cnt<N_OUT.
  - On valid&ready: out_buf[rx_cnt]<=from_net_data and rx_cnt increments.
  - RX beats may overlap TX beats; both counters advance independently in the same cycle.
- Completion:
  - The RX beat with rx_cnt==N_OUT-1 moves the FSM to DONE on that edge: done=1, busy=0, from_net_ready=0.
  - If tx_cnt<N_IN at that moment, the remaining TX beats are abandoned (to_net_valid=0). This is a protocol error by the network and is not flagged.
- from_net_valid while not in RUN: ignored, no write, ready stays 0.
- Write port:
  - wr_en is honoured in IDLE and DONE only; ignored in RUN.
  - Write takes effect on the edge.
  - A write and start on the same edge: the write lands first, so the new word is streamed.
- Result buffer is written only by RX beats and keeps its contents in DONE and IDLE until the next RUN overwrites them.
- rd_data=out_buf[rd_addr], combinational. rd_addr>=N_OUT returns 0.
- Counter widths are $clog2(N+1) bits; no wrap-around.
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronously); the partial transfer is discarded.

Test Plan:
- Load in_buf = {1,-2,3,-4} with N_IN=4, N_OUT=2. Hold to_net_ready=1. start at cycle 0 -> to_net_data = 1,-2,3,-4 on cycles 1-4 and to_net_valid=0 on cycle 5. Send rx beats 100 and -7 -> done=1, rd_data[0]=100, rd_data[1]=-7.
- TX backpressure: to_net_ready toggles 1,0,0,1,... -> each word is held stable while ready=0, exactly 4 beats are sent in order, with no duplicates or drops.
- RX backpressure and overlap: from_net_valid is presented during TX beat 2 -> the word is captured while tx_cnt continues. from_net_ready drops in the cycle after the N_OUTth beat. An extra valid beat after DONE is not written.
- start pulsed mid-RUN and wr_en mid-RUN -> no restart, in_buf unchanged, counts unaffected. Then start from DONE -> done clears, busy=1, and the stream restarts from in_buf[0].
- Assert reset at TX beat 2 -> to_net_valid, from_net_ready, busy and done drop to 0 without waiting for a clock edge, and rd_data for every address reads 0. A new start after reset -> a full clean transfer.
- rd_addr=N_OUT (out of range, non-power-of-two N_OUT=3) -> rd_data=0. Write and start on the same edge with wr_addr=0, wr_data=55 -> first beat is 55.
